// File: rtl/byte_wb_pkg.sv
// Shared command codes, EXEC opcodes and FSM state encoding for the
// byte-serial Wishbone master.
package byte_wb_pkg;

    // Host command codes carried on cmd[2:0]
    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_EXEC = 3'b001;
    localparam logic [2:0] CMD_ADR  = 3'b010;
    localparam logic [2:0] CMD_DO   = 3'b011;
    localparam logic [2:0] CMD_DI   = 3'b100;
    localparam logic [2:0] CMD_SEL  = 3'b101;
    localparam logic [2:0] CMD_STAT = 3'b110;
    localparam logic [2:0] CMD_NOP  = 3'b111;

    // EXEC opcodes carried on din
    localparam logic [7:0] OP_RESET     = 8'h01;
    localparam logic [7:0] OP_CLOSE     = 8'h04;
    localparam logic [7:0] OP_OPEN      = 8'h05;
    localparam logic [7:0] OP_READ      = 8'h06;
    localparam logic [7:0] OP_WRITE     = 8'h07;
    localparam logic [7:0] OP_READ_INC  = 8'h08;
    localparam logic [7:0] OP_WRITE_INC = 8'h09;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // no cycle, CYC low
        S_OPEN = 2'd1,   // CYC held high between transfers
        S_BUS  = 2'd2    // STB asserted, waiting for ack/err/timeout
    } state_t;

    // Opcodes that start a bus transfer
    function automatic logic op_is_launch(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE) ||
               (op == OP_READ_INC) || (op == OP_WRITE_INC);
    endfunction

    function automatic logic op_is_write(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_WRITE_INC);
    endfunction

    function automatic logic op_is_inc(input logic [7:0] op);
        return (op == OP_READ_INC) || (op == OP_WRITE_INC);
    endfunction

endpackage

// File: rtl/byte_lane_seq.sv
// Byte-lane sequencer: detects a run of one command code and walks a
// wrapping lane pointer across NB lanes, producing a one-hot lane strobe
// for the lane addressed in the current cycle.
module byte_lane_seq
    import byte_wb_pkg::*;
#(
    parameter int         NB       = 4,
    parameter logic [2:0] CMD_CODE = CMD_ADR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    cmd,
    output logic [NB-1:0] lane_we
);
    localparam int PW = (NB > 1) ? $clog2(NB) : 1;

    logic          hit;
    logic          run_q, run_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] ptr_cur;

    // Pointer restarts at lane 0 on the first cycle of a run, else advances and wraps
    always_comb begin
        hit     = (cmd == CMD_CODE);
        ptr_cur = '0;
        if (hit && run_q) begin
            ptr_cur = (ptr_q == PW'(NB - 1)) ? '0 : ptr_q + 1'b1;
        end
        run_d = hit;
        ptr_d = ptr_cur;
    end

    // Run flag and pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= 1'b0;
            ptr_q <= '0;
        end else begin
            run_q <= run_d;
            ptr_q <= ptr_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_we[gi] = hit && (ptr_cur == PW'(gi));
        end
    endgenerate

endmodule

// File: rtl/byte_cmd_wb_master.sv
// Byte-serial command port to Wishbone classic master. The host loads
// address, write data and byte selects one byte per clock, then issues
// EXEC opcodes to run single or post-incrementing bus cycles. Read data
// and status come back one byte at a time on dout.
module byte_cmd_wb_master
    import byte_wb_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DATA_BYTES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              cmd,
    input  logic [7:0]              din,
    output logic [7:0]              dout,
    output logic                    valid,
    output logic                    busy,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_W-1:0]       wb_adr_o,
    output logic [DATA_BYTES-1:0]   wb_sel_o,
    output logic [8*DATA_BYTES-1:0] wb_dat_o,
    input  logic [8*DATA_BYTES-1:0] wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);
    localparam int DW   = 8 * DATA_BYTES;
    localparam int NB_A = (ADDR_W + 7) / 8;
    localparam int TW   = 16;

    logic                  is_exec;
    logic                  rst_all;
    logic [NB_A-1:0]       adr_we;
    logic [DATA_BYTES-1:0] do_we;
    logic [DATA_BYTES-1:0] di_we;

    state_t                state_q, state_d;
    logic                  open_hold_q, open_hold_d;
    logic                  write_q, write_d;
    logic                  inc_q, inc_d;
    logic                  armed_q, armed_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  tmo_flag_q, tmo_flag_d;
    logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic [ADDR_W-1:0]     adr_q, adr_d;
    logic [DW-1:0]         do_q, do_d;
    logic [DW-1:0]         di_q, di_d;
    logic [DATA_BYTES-1:0] sel_q, sel_d;
    logic [7:0]            dout_q, dout_d;

    logic                  rd_capture;
    logic                  adr_incr;
    logic                  bus_end;
    logic [7:0]            di_byte;

    // EXEC RESET behaves exactly like the external reset
    assign is_exec = (cmd == CMD_EXEC);
    assign rst_all = reset || (is_exec && (din == OP_RESET));

    byte_lane_seq #(.NB(NB_A), .CMD_CODE(CMD_ADR)) u_adr_seq (
        .clk     (clk),
        .reset   (rst_all),
        .cmd     (cmd),
        .lane_we (adr_we)
    );

    byte_lane_seq #(.NB(DATA_BYTES), .CMD_CODE(CMD_DO)) u_do_seq (
        .clk     (clk),
        .reset   (rst_all),
        .cmd     (cmd),
        .lane_we (do_we)
    );

    byte_lane_seq #(.NB(DATA_BYTES), .CMD_CODE(CMD_DI)) u_di_seq (
        .clk     (clk),
        .reset   (rst_all),
        .cmd     (cmd),
        .lane_we (di_we)
    );

    // Bus FSM, launch arming, timeout counter and completion status
    always_comb begin
        state_d     = state_q;
        open_hold_d = open_hold_q;
        write_d     = write_q;
        inc_d       = inc_q;
        armed_d     = is_exec ? armed_q : 1'b1;
        valid_d     = valid_q;
        err_d       = err_q;
        tmo_flag_d  = tmo_flag_q;
        tmo_cnt_d   = tmo_cnt_q;
        rd_capture  = 1'b0;
        adr_incr    = 1'b0;
        bus_end     = 1'b0;

        // OPEN/CLOSE always update the hold request, even mid-cycle
        if (is_exec && (din == OP_OPEN)) begin
            open_hold_d = 1'b1;
        end
        if (is_exec && (din == OP_CLOSE)) begin
            open_hold_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_OPEN: begin
                if (is_exec && armed_q && op_is_launch(din)) begin
                    state_d    = S_BUS;
                    armed_d    = 1'b0;
                    write_d    = op_is_write(din);
                    inc_d      = op_is_inc(din);
                    valid_d    = 1'b0;
                    err_d      = 1'b0;
                    tmo_flag_d = 1'b0;
                    tmo_cnt_d  = TW'(TIMEOUT);
                end else if (is_exec && (din == OP_OPEN)) begin
                    state_d = S_OPEN;
                end else if (is_exec && (din == OP_CLOSE)) begin
                    state_d = S_IDLE;
                end
            end
            S_BUS: begin
                if (wb_ack_i) begin
                    valid_d    = 1'b1;
                    rd_capture = !write_q;
                    adr_incr   = inc_q;
                    bus_end    = 1'b1;
                end else if (wb_err_i) begin
                    err_d   = 1'b1;
                    bus_end = 1'b1;
                end else if (tmo_cnt_q <= TW'(1)) begin
                    // Last permitted STB cycle passed without a response
                    err_d      = 1'b1;
                    tmo_flag_d = 1'b1;
                    bus_end    = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
                if (bus_end) begin
                    state_d = open_hold_d ? S_OPEN : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address, write data and select loads (frozen while busy), read capture, post-increment
    always_comb begin
        adr_d = adr_q;
        do_d  = do_q;
        sel_d = sel_q;
        di_d  = di_q;
        if (!busy) begin
            for (int b = 0; b < ADDR_W; b++) begin
                if (adr_we[b / 8]) begin
                    adr_d[b] = din[b % 8];
                end
            end
            for (int l = 0; l < DATA_BYTES; l++) begin
                if (do_we[l]) begin
                    do_d[8*l +: 8] = din;
                end
            end
            if (cmd == CMD_SEL) begin
                sel_d = din[DATA_BYTES-1:0];
            end
        end
        if (adr_incr) begin
            adr_d = adr_q + 1'b1;
        end
        if (rd_capture) begin
            di_d = wb_dat_i;
        end
    end

    // Output byte mux: DI lane walk, status byte, or DI lane 0
    always_comb begin
        di_byte = '0;
        for (int l = 0; l < DATA_BYTES; l++) begin
            if (di_we[l]) begin
                di_byte = di_q[8*l +: 8];
            end
        end
        case (cmd)
            CMD_DI:   dout_d = di_byte;
            CMD_STAT: dout_d = {4'b0000, tmo_flag_q, err_q, busy, valid_q};
            default:  dout_d = di_q[7:0];
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst_all) begin
            state_q     <= S_IDLE;
            open_hold_q <= 1'b0;
            write_q     <= 1'b0;
            inc_q       <= 1'b0;
            armed_q     <= 1'b1;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            tmo_flag_q  <= 1'b0;
            tmo_cnt_q   <= '0;
            adr_q       <= '0;
            do_q        <= '0;
            di_q        <= '0;
            sel_q       <= '1;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            open_hold_q <= open_hold_d;
            write_q     <= write_d;
            inc_q       <= inc_d;
            armed_q     <= armed_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            tmo_flag_q  <= tmo_flag_d;
            tmo_cnt_q   <= tmo_cnt_d;
            adr_q       <= adr_d;
            do_q        <= do_d;
            di_q        <= di_d;
            sel_q       <= sel_d;
            dout_q      <= dout_d;
        end
    end

    assign busy     = (state_q == S_BUS);
    assign wb_stb_o = busy;
    assign wb_cyc_o = (state_q != S_IDLE);
    assign wb_we_o  = busy && write_q;
    assign wb_adr_o = adr_q;
    assign wb_sel_o = sel_q;
    assign wb_dat_o = do_q;
    assign dout     = dout_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_byte_cmd_wb_master.sv
// Self-checking bench for byte_cmd_wb_master: directed scenarios plus
// randomized transactions against a byte-level behavioural model.
module tb_byte_cmd_wb_master;
    localparam int ADDR_W     = 14;
    localparam int DATA_BYTES = 4;
    localparam int TIMEOUT    = 8;
    localparam int DW         = 8 * DATA_BYTES;
    localparam int AMASK      = (1 << ADDR_W) - 1;

    localparam logic [2:0] C_IDLE = 3'b000, C_EXEC = 3'b001, C_ADR  = 3'b010, C_DO  = 3'b011;
    localparam logic [2:0] C_DI   = 3'b100, C_SEL  = 3'b101, C_STAT = 3'b110, C_NOP = 3'b111;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [2:0]            cmd = C_IDLE;
    logic [7:0]            din = 8'h00;
    logic [7:0]            dout;
    logic                  valid, busy;
    logic                  wb_cyc_o, wb_stb_o, wb_we_o;
    logic [ADDR_W-1:0]     wb_adr_o;
    logic [DATA_BYTES-1:0] wb_sel_o;
    logic [DW-1:0]         wb_dat_o;
    logic [DW-1:0]         wb_dat_i = '0;
    logic                  wb_ack_i = 1'b0;
    logic                  wb_err_i = 1'b0;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the host-visible registers
    int unsigned m_adr;
    logic [31:0] m_do, m_di;
    logic [3:0]  m_sel;
    bit          m_valid, m_err, m_tmo, m_open;

    byte_cmd_wb_master #(.ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .din(din), .dout(dout),
        .valid(valid), .busy(busy),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_adr = 0; m_do = '0; m_di = '0; m_sel = 4'hF;
        m_valid = 0; m_err = 0; m_tmo = 0; m_open = 0;
    endtask

    function automatic logic [7:0] model_stat();
        return {4'b0000, m_tmo, m_err, 1'b0, m_valid};
    endfunction

    // Drive n consecutive bytes of one command, then a NOP to end the run
    task automatic send_bytes(input logic [2:0] c, input logic [63:0] data, input int n);
        for (int k = 0; k < n; k++) begin
            cmd = c;
            din = data[8*k +: 8];
            step();
        end
        cmd = C_NOP;
        din = 8'h00;
        step();
    endtask

    task automatic load_adr(input logic [63:0] data, input int n);
        logic [15:0] a;
        send_bytes(C_ADR, data, n);
        for (int k = 0; k < n; k++) begin
            a = 16'(m_adr);
            a[8*(k % 2) +: 8] = data[8*k +: 8];
            m_adr = int'(a) & AMASK;
        end
    endtask

    task automatic load_do(input logic [63:0] data, input int n);
        send_bytes(C_DO, data, n);
        for (int k = 0; k < n; k++) m_do[8*(k % 4) +: 8] = data[8*k +: 8];
    endtask

    task automatic load_sel(input logic [7:0] s);
        send_bytes(C_SEL, {56'h0, s}, 1);
        m_sel = s[3:0];
    endtask

    task automatic read_stat(input string name);
        cmd = C_STAT;
        step();
        checks++;
        if (dout !== model_stat()) begin
            errors++;
            $display("FAIL %s stat: got %02h expected %02h", name, dout, model_stat());
        end
        cmd = C_NOP;
    endtask

    task automatic read_di(input int n, input string name);
        logic [7:0] e;
        cmd = C_DI;
        for (int k = 0; k < n; k++) begin
            step();
            e = m_di[8*(k % 4) +: 8];
            checks++;
            if (dout !== e) begin
                errors++;
                $display("FAIL %s di[%0d]: got %02h expected %02h", name, k, dout, e);
            end
        end
        cmd = C_NOP;
        step();
    endtask

    task automatic exec_op(input logic [7:0] op, input string name);
        cmd = C_EXEC;
        din = op;
        step();
        cmd = C_NOP;
        din = 8'h00;
        if (op == 8'h05) m_open = 1;
        if (op == 8'h04) m_open = 0;
        checks++;
        if (wb_cyc_o !== m_open) begin
            errors++;
            $display("FAIL %s cyc: got %b expected %b", name, wb_cyc_o, m_open);
        end
    endtask

    // One bus transaction: kind 0 = ack at cycle ack_at, 1 = err at ack_at, 2 = no response
    task automatic run_txn(input logic [7:0] op, input int hold, input int ack_at, input int kind,
                           input logic [31:0] rdata, input logic [2:0] busy_cmd, input string name);
        int  stb_cycles, pulses, exp_cycles;
        bit  prev, done, is_wr, is_inc;
        is_wr  = (op == 8'h07) || (op == 8'h09);
        is_inc = (op == 8'h08) || (op == 8'h09);
        exp_cycles = (kind == 2) ? TIMEOUT : ack_at;
        stb_cycles = 0; pulses = 0; prev = 0; done = 0;
        wb_dat_i = rdata;
        cmd = C_EXEC;
        din = op;
        for (int c = 0; c < 60; c++) begin
            step();
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (c + 1 >= hold) begin
                cmd = busy_cmd;
                din = 8'($urandom);
            end
            if (wb_stb_o) begin
                if (!prev) pulses++;
                stb_cycles++;
                checks++;
                if (wb_cyc_o !== 1'b1 || wb_we_o !== is_wr || wb_adr_o !== ADDR_W'(m_adr) ||
                    wb_sel_o !== m_sel || (is_wr && wb_dat_o !== m_do)) begin
                    errors++;
                    $display("FAIL %s bus: got cyc=%b we=%b adr=%h sel=%h dat=%h expected cyc=1 we=%b adr=%h sel=%h dat=%h",
                             name, wb_cyc_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
                             is_wr, ADDR_W'(m_adr), m_sel, m_do);
                end
                if (kind != 2 && stb_cycles == ack_at) begin
                    if (kind == 0) wb_ack_i = 1'b1;
                    else           wb_err_i = 1'b1;
                end
            end else begin
                checks++;
                if (wb_cyc_o !== m_open) begin
                    errors++;
                    $display("FAIL %s idle_cyc: got %b expected %b", name, wb_cyc_o, m_open);
                end
            end
            prev = wb_stb_o;
            if (!wb_stb_o && stb_cycles > 0 && c + 1 >= hold) begin
                done = 1;
                break;
            end
        end
        cmd = C_NOP;
        din = 8'h00;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        checks++;
        if (!done || stb_cycles != exp_cycles || pulses != 1) begin
            errors++;
            $display("FAIL %s stb: got done=%0d cycles=%0d pulses=%0d expected done=1 cycles=%0d pulses=1",
                     name, done, stb_cycles, pulses, exp_cycles);
        end
        // Model: apply the transaction outcome
        m_valid = (kind == 0);
        m_err   = (kind != 0);
        m_tmo   = (kind == 2);
        if (kind == 0 && !is_wr) m_di = rdata;
        if (kind == 0 && is_inc) m_adr = (m_adr + 1) & AMASK;
        checks++;
        if (valid !== m_valid || busy !== 1'b0 || wb_adr_o !== ADDR_W'(m_adr)) begin
            errors++;
            $display("FAIL %s post: got valid=%b busy=%b adr=%h expected valid=%b busy=0 adr=%h",
                     name, valid, busy, wb_adr_o, m_valid, ADDR_W'(m_adr));
        end
        $display("txn %s op=%02h kind=%0d stb_cycles=%0d adr=%h", name, op, kind, stb_cycles, wb_adr_o);
        read_stat(name);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        model_reset();
        checks++;
        if (wb_cyc_o !== 0 || wb_stb_o !== 0 || wb_we_o !== 0 || valid !== 0 || busy !== 0 ||
            dout !== 8'h00 || wb_sel_o !== 4'hF || wb_adr_o !== '0 || wb_dat_o !== '0) begin
            errors++;
            $display("FAIL reset: got cyc=%b stb=%b we=%b valid=%b busy=%b dout=%h sel=%h adr=%h dat=%h expected 0 except sel=F",
                     wb_cyc_o, wb_stb_o, wb_we_o, valid, busy, dout, wb_sel_o, wb_adr_o, wb_dat_o);
        end
        $display("txn reset done");
    endtask

    task automatic test_write_directed();
        load_adr(64'h1234, 2);
        load_do(64'h1234_5678, 4);
        run_txn(8'h07, 5, 2, 0, 32'($urandom), C_IDLE, "write_hold");
        checks++;
        if (wb_adr_o !== 14'h1234 || wb_dat_o !== 32'h1234_5678 || valid !== 1'b1) begin
            errors++;
            $display("FAIL write_directed: got adr=%h dat=%h valid=%b expected 1234 12345678 1",
                     wb_adr_o, wb_dat_o, valid);
        end
    endtask

    task automatic test_read_di();
        run_txn(8'h06, 1, 1, 0, 32'hCAFE_BABE, C_IDLE, "read");
        read_di(5, "read_di_wrap");
    endtask

    task automatic test_sel_inc_wrap();
        load_sel(8'h03);
        load_adr(64'h3FFF, 2);
        run_txn(8'h09, 1, 1, 0, 32'($urandom), C_IDLE, "write_inc_wrap");
        checks++;
        if (wb_adr_o !== 14'h0000 || wb_sel_o !== 4'h3) begin
            errors++;
            $display("FAIL inc_wrap: got adr=%h sel=%h expected 0000 3", wb_adr_o, wb_sel_o);
        end
    endtask

    task automatic test_timeout();
        run_txn(8'h07, 1, 0, 2, 32'($urandom), C_IDLE, "timeout");
    endtask

    task automatic test_err_soft_reset();
        run_txn(8'h06, 1, 3, 1, 32'($urandom), C_IDLE, "err");
        cmd = C_EXEC;
        din = 8'h07;
        step();
        cmd = C_IDLE;
        din = 8'h00;
        checks++;
        if (wb_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL soft_reset launch: got stb=%b expected 1", wb_stb_o);
        end
        step();
        cmd = C_EXEC;
        din = 8'h01;
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        cmd = C_NOP;
        din = 8'h00;
        model_reset();
        checks++;
        if (wb_cyc_o !== 0 || wb_stb_o !== 0 || valid !== 0 || wb_sel_o !== 4'hF || wb_adr_o !== '0) begin
            errors++;
            $display("FAIL soft_reset: got cyc=%b stb=%b valid=%b sel=%h adr=%h expected 0 0 0 F 0",
                     wb_cyc_o, wb_stb_o, valid, wb_sel_o, wb_adr_o);
        end
        $display("txn soft_reset done");
        read_stat("soft_reset");
        read_di(1, "soft_reset_di");
    endtask

    task automatic test_open_hold();
        exec_op(8'h05, "open");
        load_adr({48'h0, 16'($urandom)}, 2);
        run_txn(8'h08, 1, $urandom_range(1, TIMEOUT), 0, 32'($urandom), C_IDLE, "open_rd_inc1");
        cmd = C_IDLE;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (wb_cyc_o !== 1'b1) begin
                errors++;
                $display("FAIL open_gap cyc: got %b expected 1", wb_cyc_o);
            end
        end
        run_txn(8'h08, 1, $urandom_range(1, TIMEOUT), 0, 32'($urandom), C_IDLE, "open_rd_inc2");
        read_di(4, "open_di");
        exec_op(8'h04, "close");
    endtask

    task automatic test_stray_ack();
        cmd = C_NOP;
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        wb_dat_i = 32'($urandom);
        repeat (3) step();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        read_stat("stray_ack");
        read_di(4, "stray_ack_di");
    endtask

    task automatic test_random();
        logic [7:0] ops [4];
        logic [2:0] bcmds [4];
        int kind, r, hold;
        logic [2:0] bc;
        ops   = '{8'h06, 8'h07, 8'h08, 8'h09};
        bcmds = '{C_IDLE, C_ADR, C_DO, C_SEL};
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 3) == 0) exec_op(m_open ? 8'h04 : 8'h05, "rand_openclose");
            load_adr({$urandom, $urandom}, $urandom_range(2, 3));
            load_do({$urandom, $urandom}, $urandom_range(4, 5));
            if ($urandom_range(0, 1) == 1) load_sel(8'($urandom));
            r    = $urandom_range(0, 9);
            kind = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
            hold = $urandom_range(1, 3);
            bc   = (hold == 1) ? bcmds[$urandom_range(0, 3)] : C_IDLE;
            run_txn(ops[$urandom_range(0, 3)], hold, $urandom_range(1, TIMEOUT), kind,
                    32'($urandom), bc, "random");
            read_di(4, "random_di");
        end
        if (m_open) exec_op(8'h04, "rand_close");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_directed();
        test_read_di();
        test_sel_inc_wrap();
        test_timeout();
        test_err_soft_reset();
        test_open_hold();
        test_stray_ack();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
